// File: rtl/conv_pkg.sv
// Shared definitions for the streaming convolution datapath: default widths and
// elaboration-time helpers used by the PE, the convolution top and the bench.
package conv_pkg;

    localparam int DEF_KERNEL_SIZE = 3;
    localparam int DEF_FM_SIZE     = 8;
    localparam int DEF_STRIDE      = 1;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_WEIGHT_W    = 18;
    localparam int DEF_ACC_W       = 48;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Output positions along one axis; partial windows at the far edge are dropped.
    function automatic int out_dim(input int fm, input int k, input int s);
        return (fm - k) / s + 1;
    endfunction

endpackage

// File: rtl/conv_window_pe_if.sv
// Pixel-in / window-sum-out bundle of the convolution PE.
interface conv_window_pe_if #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_W      = 16,
    parameter int WEIGHT_W    = 18,
    parameter int ACC_W       = 48
) ();

    logic                                          i_valid;
    logic signed [DATA_W-1:0]                      i_data;
    logic [KERNEL_SIZE*KERNEL_SIZE*WEIGHT_W-1:0]   i_weight;
    logic                                          o_valid;
    logic signed [ACC_W-1:0]                       o_data;
    logic                                          o_last;

    modport master (
        output i_valid, i_data, i_weight,
        input  o_valid, o_data, o_last
    );

    modport slave (
        input  i_valid, i_data, i_weight,
        output o_valid, o_data, o_last
    );

endinterface

// File: rtl/conv_window_pe_line_buffer.sv
// One feature-map row of delay: the output is the pixel accepted FM_SIZE beats earlier,
// i.e. the same column of the previous row.
module pe_line_buffer #(
    parameter int DATA_W  = 16,
    parameter int FM_SIZE = 8
) (
    input  logic                     i_clk,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_data,
    output logic signed [DATA_W-1:0] o_data
);

    logic signed [DATA_W-1:0] mem_q [FM_SIZE];

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            mem_q[0] <= i_data;
            for (int i = 1; i < FM_SIZE; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign o_data = mem_q[FM_SIZE-1];

endmodule

// File: rtl/conv_window_pe.sv
// Streaming KxK convolution PE: line buffers build the window, stage 1 registers the
// K*K full-precision products, stage 2 registers their exact sum.
module conv_window_pe
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int FM_SIZE     = DEF_FM_SIZE,
    parameter int STRIDE      = DEF_STRIDE,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WEIGHT_W    = DEF_WEIGHT_W,
    parameter int ACC_W       = DEF_ACC_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    conv_window_pe_if.slave  bus
);

    localparam int K        = KERNEL_SIZE;
    localparam int KK       = K * K;
    localparam int PROD_W   = DATA_W + WEIGHT_W;
    localparam int CNT_W    = (clog2(FM_SIZE) < 1) ? 1 : clog2(FM_SIZE);
    localparam int LAST_POS = FM_SIZE - 1 - ((FM_SIZE - K) % STRIDE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FM_SIZE - 1);

    function automatic logic signed [PROD_W-1:0] mul_full(
        input logic signed [DATA_W-1:0]   a,
        input logic signed [WEIGHT_W-1:0] b
    );
        return PROD_W'(a) * PROD_W'(b);
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_acc(input logic signed [PROD_W-1:0] p);
        return ACC_W'(p);
    endfunction

    // A beat coinciding with reset is dropped.
    logic beat;
    assign beat = bus.i_valid & ~i_rst;

    logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
    logic             win_ok, win_last;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (beat) begin
            if (col_q == CNT_MAX) begin
                col_d = '0;
                row_d = (row_q == CNT_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        int r_off;
        int c_off;
        r_off    = int'(row_q) - (K - 1);
        c_off    = int'(col_q) - (K - 1);
        win_ok   = (r_off >= 0) && (c_off >= 0) &&
                   ((r_off % STRIDE) == 0) && ((c_off % STRIDE) == 0);
        win_last = (int'(row_q) == LAST_POS) && (int'(col_q) == LAST_POS);
    end

    // col_pix[r] is the incoming column: r=K-1 is the live pixel, r=0 the oldest row.
    logic signed [DATA_W-1:0] col_pix [K];
    assign col_pix[K-1] = bus.i_data;

    for (genvar j = 0; j < K - 1; j++) begin : g_lb
        pe_line_buffer #(
            .DATA_W  (DATA_W),
            .FM_SIZE (FM_SIZE)
        ) u_lb (
            .i_clk  (i_clk),
            .i_en   (beat),
            .i_data (col_pix[K-1-j]),
            .o_data (col_pix[K-2-j])
        );
    end

    // win_q keeps the K-1 newest columns; win_d is the full window for the current beat.
    logic signed [DATA_W-1:0] win_q [K][K-1];
    logic signed [DATA_W-1:0] win_d [K][K];

    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_d[r][c] = (c == K - 1) ? col_pix[r] : win_q[r][c];
            end
        end
    end

    // ---- stage 1: window shift and K*K products ----
    logic signed [PROD_W-1:0] prod_p1_q [KK];
    logic                     vld_p1_q, last_p1_q;

    always_ff @(posedge i_clk) begin
        if (beat) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_q[r][c] <= win_d[r][c+1];
                end
            end
            for (int k = 0; k < KK; k++) begin
                prod_p1_q[k] <= mul_full(win_d[k/K][k%K],
                                         $signed(bus.i_weight[k*WEIGHT_W +: WEIGHT_W]));
            end
        end
    end

    // ---- stage 2: exact sum of the products ----
    logic signed [ACC_W-1:0] acc_p1;
    logic signed [ACC_W-1:0] data_p2_q;
    logic                    vld_p2_q, last_p2_q;

    always_comb begin
        acc_p1 = '0;
        for (int k = 0; k < KK; k++) begin
            acc_p1 = acc_p1 + sext_acc(prod_p1_q[k]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            row_q     <= '0;
            col_q     <= '0;
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            vld_p2_q  <= 1'b0;
            last_p2_q <= 1'b0;
            data_p2_q <= '0;
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            vld_p1_q  <= beat & win_ok;
            last_p1_q <= beat & win_ok & win_last;
            vld_p2_q  <= vld_p1_q;
            last_p2_q <= last_p1_q;
            if (vld_p1_q) data_p2_q <= acc_p1;
        end
    end

    assign bus.o_valid = vld_p2_q;
    assign bus.o_data  = data_p2_q;
    assign bus.o_last  = last_p2_q;

endmodule

// File: tb/tb_conv_window_pe.sv
// Scoreboard bench: three PEs (stride 1, stride 2, narrow 8-bit) share one pixel stream;
// a frame-array reference model queues expected sums, a negedge monitor checks them.
module tb_conv_window_pe;
    import conv_pkg::*;

    localparam int K   = 3;
    localparam int FM  = 5;
    localparam int KK  = K * K;
    localparam int DWA = 16;
    localparam int WWA = 18;
    localparam int AWA = 48;
    localparam int DWC = 8;
    localparam int WWC = 8;
    localparam int AWC = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_window_pe_if #(.KERNEL_SIZE(K), .DATA_W(DWA), .WEIGHT_W(WWA), .ACC_W(AWA)) bus_a ();
    conv_window_pe_if #(.KERNEL_SIZE(K), .DATA_W(DWA), .WEIGHT_W(WWA), .ACC_W(AWA)) bus_b ();
    conv_window_pe_if #(.KERNEL_SIZE(K), .DATA_W(DWC), .WEIGHT_W(WWC), .ACC_W(AWC)) bus_c ();

    conv_window_pe #(.KERNEL_SIZE(K), .FM_SIZE(FM), .STRIDE(1), .DATA_W(DWA),
                     .WEIGHT_W(WWA), .ACC_W(AWA)) dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
    conv_window_pe #(.KERNEL_SIZE(K), .FM_SIZE(FM), .STRIDE(2), .DATA_W(DWA),
                     .WEIGHT_W(WWA), .ACC_W(AWA)) dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));
    conv_window_pe #(.KERNEL_SIZE(K), .FM_SIZE(FM), .STRIDE(1), .DATA_W(DWC),
                     .WEIGHT_W(WWC), .ACC_W(AWC)) dut_c (.i_clk(clk), .i_rst(rst), .bus(bus_c));

    typedef struct {
        longint v;
        bit     last;
        int     due;
    } exp_t;

    exp_t q [3][$];
    int   nout [3];
    int   fr [FM][FM];
    int   wts [KK];
    int   mrow, mcol;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int stride_of(input int id);
        return (id == 1) ? 2 : 1;
    endfunction

    function automatic int trunc(input int v, input int w);
        int t;
        t = v <<< (32 - w);
        return t >>> (32 - w);
    endfunction

    function automatic longint win_sum(input int r0, input int c0, input int dw, input int ww);
        longint s;
        s = 0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                s += longint'(trunc(fr[r0+r][c0+c], dw)) * longint'(trunc(wts[r*K+c], ww));
        return s;
    endfunction

    function automatic void chk(input string name, input longint act, input longint req);
        nchk++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Record the pixel at the model's position; queue a sum for every DUT whose window completes.
    function automatic void model_step(input int v);
        exp_t e;
        int   s, lp;
        fr[mrow][mcol] = v;
        for (int id = 0; id < 3; id++) begin
            s  = stride_of(id);
            lp = FM - 1 - ((FM - K) % s);
            if (mrow >= K - 1 && mcol >= K - 1 &&
                ((mrow - K + 1) % s) == 0 && ((mcol - K + 1) % s) == 0) begin
                e.v    = win_sum(mrow - K + 1, mcol - K + 1,
                                 (id == 2) ? DWC : DWA, (id == 2) ? WWC : WWA);
                e.last = (mrow == lp) && (mcol == lp);
                e.due  = cyc + 2;
                q[id].push_back(e);
            end
        end
        mcol++;
        if (mcol == FM) begin
            mcol = 0;
            mrow = (mrow == FM - 1) ? 0 : mrow + 1;
        end
    endfunction

    function automatic void mon(input int id, input logic v, input longint d, input logic l);
        exp_t e;
        if (v) begin
            if (q[id].size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_out dut%0d: got o_valid=1 data %0d, required no output (cycle %0d)",
                         id, d, cyc);
            end else begin
                e = q[id].pop_front();
                chk($sformatf("data_dut%0d", id), d, e.v);
                chk($sformatf("last_dut%0d", id), longint'(l), longint'(e.last));
                chk($sformatf("latency_dut%0d", id), cyc, e.due);
                nout[id]++;
                if (l) begin
                    chk($sformatf("frame_count_dut%0d", id), nout[id],
                        out_dim(FM, K, stride_of(id)) * out_dim(FM, K, stride_of(id)));
                    nout[id] = 0;
                end
            end
        end else if (q[id].size() != 0 && q[id][0].due < cyc) begin
            nchk++;
            nerr++;
            $display("FAIL missed_out dut%0d: got no output, required data %0d at cycle %0d",
                     id, q[id][0].v, q[id][0].due);
            void'(q[id].pop_front());
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, bus_a.o_valid, longint'(bus_a.o_data), bus_a.o_last);
            mon(1, bus_b.o_valid, longint'(bus_b.o_data), bus_b.o_last);
            mon(2, bus_c.o_valid, longint'(bus_c.o_data), bus_c.o_last);
        end
    end

    task automatic set_w(input int mode);
        for (int k = 0; k < KK; k++) begin
            case (mode)
                0:       wts[k] = 1;
                1:       wts[k] = (k == 4) ? 1 : 0;
                2:       wts[k] = -128;
                default: wts[k] = int'($urandom_range(0, 262143)) - 131072;
            endcase
            bus_a.i_weight[k*WWA +: WWA] = WWA'(wts[k]);
            bus_b.i_weight[k*WWA +: WWA] = WWA'(wts[k]);
            bus_c.i_weight[k*WWC +: WWC] = WWC'(wts[k]);
        end
    endtask

    task automatic idle();
        int junk;
        junk = int'($urandom);
        bus_a.i_valid = 1'b0;
        bus_b.i_valid = 1'b0;
        bus_c.i_valid = 1'b0;
        bus_a.i_data  = DWA'(junk);
        bus_b.i_data  = DWA'(junk);
        bus_c.i_data  = DWC'(junk);
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int v);
        bus_a.i_valid = 1'b1;
        bus_b.i_valid = 1'b1;
        bus_c.i_valid = 1'b1;
        bus_a.i_data  = DWA'(v);
        bus_b.i_data  = DWA'(v);
        bus_c.i_data  = DWC'(v);
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    // mode: 0 ones, 1 ramp row*FM+col, 2 constant -128, 3 random 16-bit
    task automatic send_frame(input int mode, input bit gaps, input int npix);
        int v;
        for (int p = 0; p < npix; p++) begin
            case (mode)
                0:       v = 1;
                1:       v = p;
                2:       v = -128;
                default: v = int'($urandom_range(0, 65535)) - 32768;
            endcase
            if (gaps && $urandom_range(0, 1) == 1) idle();
            beat(v);
        end
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        bus_a.i_valid = 1'b0;
        bus_b.i_valid = 1'b0;
        bus_c.i_valid = 1'b0;
        for (int id = 0; id < 3; id++) begin
            while (q[id].size() != 0 && q[id][q[id].size()-1].due > cyc) void'(q[id].pop_back());
            nout[id] = 0;
        end
        mrow = 0;
        mcol = 0;
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time bound at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mrow = 0;
        mcol = 0;
        for (int id = 0; id < 3; id++) nout[id] = 0;
        bus_a.i_valid = 1'b0;
        bus_b.i_valid = 1'b0;
        bus_c.i_valid = 1'b0;
        bus_a.i_data  = '0;
        bus_b.i_data  = '0;
        bus_c.i_data  = '0;
        set_w(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_o_valid_a", longint'(bus_a.o_valid), 0);
        chk("reset_o_data_a",  longint'(bus_a.o_data), 0);
        chk("reset_o_last_a",  longint'(bus_a.o_last), 0);
        chk("reset_o_valid_b", longint'(bus_b.o_valid), 0);
        chk("reset_o_data_b",  longint'(bus_b.o_data), 0);
        chk("reset_o_valid_c", longint'(bus_c.o_valid), 0);
        chk("reset_o_data_c",  longint'(bus_c.o_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        set_w(0); send_frame(0, 1'b0, FM*FM);
        set_w(1); send_frame(1, 1'b0, FM*FM);
        set_w(2); send_frame(2, 1'b0, FM*FM);
        set_w(1); send_frame(1, 1'b1, FM*FM);
        repeat (3) idle();
        send_frame(1, 1'b0, FM*FM);
        send_frame(1, 1'b0, FM*FM);
        set_w(3); send_frame(3, 1'b0, FM*FM);
        set_w(3); send_frame(3, 1'b1, FM*FM);
        repeat (4) idle();

        set_w(1);
        send_frame(1, 1'b0, 7);
        do_reset(2);
        send_frame(1, 1'b0, FM*FM);
        repeat (6) idle();

        chk("drain_a", q[0].size(), 0);
        chk("drain_b", q[1].size(), 0);
        chk("drain_c", q[2].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
